rule_conf_master: RTL and testbench

RULE_CONF_MASTER -- requirements
Module: Rule_Conf_Master

---
 rtl/rule_conf_master_pkg.sv | 20 ++
 rtl/rule_conf_master.sv | 147 ++++++++++++++
 tb/tb_rule_conf_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rule_conf_master_pkg.sv
// rule_conf_master_pkg -- types and widths shared by the rule configuration layers.
// Rev 1.0
`default_nettype none

package rule_conf_master_pkg;

  localparam int RULE_ADDR_WIDTH = 32;
  localparam int RULE_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WR_GAP  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } conf_state_e;

endpackage

`default_nettype wire

// File: rtl/rule_conf_master.sv
// rule_conf_master -- single-outstanding host request master toward the layer conf port.
// Rev 1.0
`default_nettype none

module rule_conf_master
  import rule_conf_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int WR_GAP_CYC  = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_write,
  input  logic [RULE_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [RULE_DATA_WIDTH-1:0] i_req_wdata,
  output logic                       o_resp_valid,
  input  logic                       i_resp_ready,
  output logic [RULE_DATA_WIDTH-1:0] o_resp_rdata,
  output logic                       o_resp_err,
  output logic                       o_rule_wren,
  output logic                       o_rule_rden,
  output logic [RULE_ADDR_WIDTH-1:0] o_rule_addr,
  output logic [RULE_DATA_WIDTH-1:0] o_rule_wdata,
  input  logic                       i_rule_rdata_valid,
  input  logic [RULE_DATA_WIDTH-1:0] i_rule_rdata,
  output logic [15:0]                o_err_cnt
);

  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYC - 1);
  localparam logic [7:0] GAP_LAST = 8'(WR_GAP_CYC - 1);

  conf_state_e                state_q;
  logic                       req_ready_q;
  logic                       wr_q;
  logic                       rule_wren_q;
  logic                       rule_rden_q;
  logic [RULE_ADDR_WIDTH-1:0] rule_addr_q;
  logic [RULE_DATA_WIDTH-1:0] rule_wdata_q;
  logic                       resp_valid_q;
  logic [RULE_DATA_WIDTH-1:0] resp_rdata_q;
  logic                       resp_err_q;
  logic [7:0]                 cnt_q;
  logic [15:0]                err_cnt_q;
  logic [15:0]                err_cnt_d;

  assign err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      wr_q         <= 1'b0;
      rule_wren_q  <= 1'b0;
      rule_rden_q  <= 1'b0;
      rule_addr_q  <= '0;
      rule_wdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      cnt_q        <= 8'd0;
      err_cnt_q    <= 16'd0;
    end else begin
      // Strobes are single-cycle pulses that only ever cover the ISSUE cycle.
      rule_wren_q <= 1'b0;
      rule_rden_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (i_req_valid && req_ready_q) begin
            req_ready_q  <= 1'b0;
            wr_q         <= i_req_write;
            rule_addr_q  <= i_req_addr;
            rule_wdata_q <= i_req_wdata;
            rule_wren_q  <= i_req_write;
            rule_rden_q  <= !i_req_write;
            cnt_q        <= 8'd0;
            state_q      <= ISSUE;
          end
        end
        ISSUE, RD_WAIT: begin
          if (state_q == ISSUE && wr_q) begin
            cnt_q <= 8'd0;
            if (WR_GAP_CYC == 0) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_err_q   <= 1'b0;
              state_q      <= RESP;
            end else begin
              state_q <= WR_GAP;
            end
          end else if (i_rule_rdata_valid) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= i_rule_rdata;
            resp_err_q   <= 1'b0;
            state_q      <= RESP;
          end else if (cnt_q == TO_LAST) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
            err_cnt_q    <= err_cnt_d;
            state_q      <= RESP;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
            state_q <= RD_WAIT;
          end
        end
        WR_GAP: begin
          if (cnt_q == GAP_LAST) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = req_ready_q;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_rdata = resp_rdata_q;
  assign o_resp_err   = resp_err_q;
  assign o_rule_wren  = rule_wren_q;
  assign o_rule_rden  = rule_rden_q;
  assign o_rule_addr  = rule_addr_q;
  assign o_rule_wdata = rule_wdata_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rule_conf_master.sv
// tb_rule_conf_master -- randomized self-checking bench against a cycle-offset reference model.
// Rev 1.0
`default_nettype none

module tb_rule_conf_master;

  localparam int TO  = 16;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b0;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_rule_wren;
  logic        o_rule_rden;
  logic [31:0] o_rule_addr;
  logic [31:0] o_rule_wdata;
  logic        i_rule_rdata_valid = 1'b0;
  logic [31:0] i_rule_rdata = '0;
  logic [15:0] o_err_cnt;

  int          n_tests = 0;
  int          n_fail = 0;
  int          model_err = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;

  always #5 clk = ~clk;

  rule_conf_master #(.TIMEOUT_CYC(TO), .WR_GAP_CYC(GAP)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_req_valid        (i_req_valid),
    .o_req_ready        (o_req_ready),
    .i_req_write        (i_req_write),
    .i_req_addr         (i_req_addr),
    .i_req_wdata        (i_req_wdata),
    .o_resp_valid       (o_resp_valid),
    .i_resp_ready       (i_resp_ready),
    .o_resp_rdata       (o_resp_rdata),
    .o_resp_err         (o_resp_err),
    .o_rule_wren        (o_rule_wren),
    .o_rule_rden        (o_rule_rden),
    .o_rule_addr        (o_rule_addr),
    .o_rule_wdata       (o_rule_wdata),
    .i_rule_rdata_valid (i_rule_rdata_valid),
    .i_rule_rdata       (i_rule_rdata),
    .o_err_cnt          (o_err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response offset in cycles after the acceptance edge (ISSUE is offset 1).
  function automatic int exp_resp_n(input bit wr, input int lat);
    if (wr) return 2 + GAP;
    if (lat >= 0 && lat < TO) return 2 + lat;
    return 1 + TO;
  endfunction

  // Entered and left at #1 after a rising edge, with the DUT idle.
  // lat: ISSUE-relative cycle of the first rdata_valid (-1 = never).
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdat, input int lat, input bit dbl,
                         input int bp, input bit hold_valid);
    int          en;
    bit          tmo;
    bit          done;
    logic [31:0] e_rdata;
    en      = exp_resp_n(wr, lat);
    tmo     = !wr && !(lat >= 0 && lat < TO);
    e_rdata = (wr || tmo) ? 32'd0 : rdat;
    check_eq("req_ready_idle", 32'(o_req_ready), 32'd1);
    check_eq("addr_hold_idle", o_rule_addr, last_addr);
    check_eq("wdata_hold_idle", o_rule_wdata, last_wdata);
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    @(posedge clk);
    #1;
    i_req_valid = hold_valid;
    i_req_addr  = $urandom;
    i_req_wdata = $urandom;
    last_addr   = addr;
    last_wdata  = wdata;
    done        = 1'b0;
    for (int n = 1; n <= en + bp + 4 && !done; n++) begin
      check_eq("wren", 32'(o_rule_wren), 32'(n == 1 && wr));
      check_eq("rden", 32'(o_rule_rden), 32'(n == 1 && !wr));
      check_eq("rule_addr", o_rule_addr, addr);
      check_eq("rule_wdata", o_rule_wdata, wdata);
      check_eq("req_ready_busy", 32'(o_req_ready), 32'd0);
      check_eq("resp_valid", 32'(o_resp_valid), 32'(n >= en));
      if (o_resp_valid) begin
        check_eq("resp_rdata", o_resp_rdata, e_rdata);
        check_eq("resp_err", 32'(o_resp_err), 32'(tmo));
      end
      i_rule_rdata_valid = (lat >= 0 && n - 1 == lat) || (dbl && lat >= 0 && n - 1 == lat + 1);
      i_rule_rdata       = (n - 1 == lat) ? rdat : ~rdat;
      i_resp_ready       = (n >= en + bp);
      done               = o_resp_valid && i_resp_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("handshake_timeout", 32'd0, 32'd1);
    i_req_valid        = 1'b0;
    i_rule_rdata_valid = 1'b0;
    i_resp_ready       = 1'b0;
    if (tmo && model_err < 65535) model_err++;
    check_eq("err_cnt", 32'(o_err_cnt), 32'(model_err));
    check_eq("resp_valid_after", 32'(o_resp_valid), 32'd0);
  endtask

  task automatic idle_stray(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      i_rule_rdata_valid = 1'($urandom_range(0, 1));
      i_rule_rdata       = $urandom;
      @(posedge clk);
      #1;
      check_eq("stray_resp_valid", 32'(o_resp_valid), 32'd0);
      check_eq("stray_strobes", 32'({o_rule_wren, o_rule_rden}), 32'd0);
      check_eq("stray_err_cnt", 32'(o_err_cnt), 32'(model_err));
    end
    i_rule_rdata_valid = 1'b0;
  endtask

  bit          r_wr;
  int          r_lat;
  int          r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdat;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_ctrl", 32'({o_req_ready, o_resp_valid, o_resp_err, o_rule_wren, o_rule_rden}), 32'd0);
    check_eq("rst_err_cnt", 32'(o_err_cnt), 32'd0);
    check_eq("rst_rule_addr", o_rule_addr, 32'd0);
    check_eq("rst_rule_wdata", o_rule_wdata, 32'd0);
    check_eq("rst_resp_rdata", o_resp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases: nominal write, zero-latency read, timeouts, window edges, backpressure.
    run_txn(1'b1, 32'h10, 32'hA5A5_0001, 32'h0, -1, 1'b0, 0, 1'b0);
    run_txn(1'b0, 32'h20, 32'h0, 32'h1234_5678, 0, 1'b0, 0, 1'b0);
    run_txn(1'b0, 32'h30, 32'h0, 32'h0, -1, 1'b0, 0, 1'b1);
    run_txn(1'b0, 32'h34, 32'h0, 32'h0, -1, 1'b0, 2, 1'b0);
    run_txn(1'b0, 32'h40, 32'h0, 32'hCAFE_0001, TO - 1, 1'b0, 0, 1'b0);
    run_txn(1'b0, 32'h44, 32'h0, 32'hCAFE_0002, TO, 1'b0, 0, 1'b0);
    run_txn(1'b1, 32'h50, 32'h5555_AAAA, 32'h0, -1, 1'b0, 10, 1'b1);
    run_txn(1'b0, 32'h54, 32'h0, 32'h8765_4321, 5, 1'b0, 10, 1'b0);
    idle_stray(4);
    run_txn(1'b0, 32'h60, 32'h0, 32'hBEEF_0003, 2, 1'b1, 0, 1'b0);
    run_txn(1'b0, 32'h64, 32'h0, 32'hBEEF_0004, 0, 1'b1, 1, 1'b0);

    // Reset while waiting on read data abandons the transaction.
    i_req_valid = 1'b1;
    i_req_write = 1'b0;
    i_req_addr  = 32'h77;
    i_req_wdata = 32'h0;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_ctrl", 32'({o_req_ready, o_resp_valid, o_resp_err, o_rule_wren, o_rule_rden}), 32'd0);
    check_eq("midrst_err_cnt", 32'(o_err_cnt), 32'd0);
    check_eq("midrst_rule_addr", o_rule_addr, 32'd0);
    check_eq("midrst_resp_rdata", o_resp_rdata, 32'd0);
    model_err  = 0;
    last_addr  = '0;
    last_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", 32'(o_req_ready), 32'd1);
    for (int i = 0; i < TO + 4; i++) begin
      check_eq("post_rst_no_resp", 32'({o_resp_valid, o_rule_wren, o_rule_rden}), 32'd0);
      @(posedge clk);
      #1;
    end
    run_txn(1'b0, 32'h78, 32'h0, 32'h0BAD_F00D, 3, 1'b0, 0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_rdat  = $urandom;
      r_sel   = $urandom_range(0, 9);
      if (r_sel == 0)      r_lat = -1;
      else if (r_sel == 1) r_lat = TO - 1;
      else if (r_sel == 2) r_lat = TO;
      else                 r_lat = $urandom_range(0, 6);
      idle_stray($urandom_range(0, 2));
      run_txn(r_wr, r_addr, r_wdata, r_rdat, r_lat, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
